// File: rtl/ram_1wnr_sync_backpressure_pkg.sv
// Byte-granular helpers shared by the RAM top and its read-channel controllers.
package ram_pkg;

  localparam int BYTE_W = 8;

  function automatic logic [BYTE_W-1:0] expand_mask_bit(input logic en);
    return {BYTE_W{en}};
  endfunction

  function automatic logic [BYTE_W-1:0] merge_byte(
    input logic [BYTE_W-1:0] old_byte,
    input logic [BYTE_W-1:0] new_byte,
    input logic [BYTE_W-1:0] bit_mask
  );
    return (old_byte & ~bit_mask) | (new_byte & bit_mask);
  endfunction

endpackage

// File: rtl/ram_1wnr_sync_backpressure_rd_chan.sv
// One read channel: request/response handshake, stall reissue and write-bypass merge.
module ram_rd_chan_ctrl
  import ram_pkg::*;
#(
  parameter int width_p  = 64,
  parameter int addr_w_p = 8,
  parameter int mask_w_p = width_p / 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_val,
  input  logic [addr_w_p-1:0] req_addr,
  output logic                req_rdy,
  output logic                resp_val,
  output logic [width_p-1:0]  resp_data,
  input  logic                resp_rdy,
  output logic                issue_en,
  output logic [addr_w_p-1:0] issue_addr,
  input  logic [width_p-1:0]  raw_data,
  input  logic                wcap_val,
  input  logic [addr_w_p-1:0] wcap_addr,
  input  logic [width_p-1:0]  wcap_data,
  input  logic [mask_w_p-1:0] wcap_mask
);

  logic                vld_p1;
  logic [addr_w_p-1:0] addr_p1;
  logic                accept;
  logic                stall;
  logic                hit;

  assign req_rdy    = resp_rdy | ~vld_p1;
  assign accept     = req_val & req_rdy;
  assign stall      = vld_p1 & ~resp_rdy;
  assign issue_en   = accept | stall;
  assign issue_addr = stall ? addr_p1 : req_addr;

  // Stage p0 -> p1: issue registers; a stall keeps the held address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
    end else begin
      vld_p1 <= issue_en;
      if (accept) addr_p1 <= req_addr;
    end
  end

  assign resp_val = vld_p1;
  assign hit      = vld_p1 & wcap_val & (wcap_addr == addr_p1);

  // Stage p1 output: array read was pre-write, so fold in the same-cycle write.
  for (genvar i = 0; i < mask_w_p; i++) begin : g_merge
    assign resp_data[i*BYTE_W +: BYTE_W] = merge_byte(raw_data[i*BYTE_W +: BYTE_W],
                                                      wcap_data[i*BYTE_W +: BYTE_W],
                                                      expand_mask_bit(hit & wcap_mask[i]));
  end

endmodule

// File: rtl/ram_1wnr_sync_backpressure.sv
// Byte-masked single-write, multi-read synchronous RAM with per-channel backpressure.
module ram_1wnr_sync_backpressure
  import ram_pkg::*;
#(
  parameter int width_p        = 64,
  parameter int els_p          = 256,
  parameter int num_rd_ports_p = 2,
  parameter int addr_w_p       = (els_p > 1) ? $clog2(els_p) : 1,
  parameter int mask_w_p       = width_p / 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_req_val,
  input  logic [addr_w_p-1:0]                wr_req_addr,
  input  logic [width_p-1:0]                 wr_req_data,
  input  logic [mask_w_p-1:0]                wr_req_mask,
  output logic                               wr_req_rdy,
  input  logic [num_rd_ports_p-1:0]          rd_req_val,
  input  logic [num_rd_ports_p*addr_w_p-1:0] rd_req_addr,
  output logic [num_rd_ports_p-1:0]          rd_req_rdy,
  output logic [num_rd_ports_p-1:0]          rd_resp_val,
  output logic [num_rd_ports_p*width_p-1:0]  rd_resp_data,
  input  logic [num_rd_ports_p-1:0]          rd_resp_rdy
);

  logic [width_p-1:0]  mem [els_p];

  logic                wcap_vld_p1;
  logic [addr_w_p-1:0] wcap_addr_p1;
  logic [width_p-1:0]  wcap_data_p1;
  logic [mask_w_p-1:0] wcap_mask_p1;

  assign wr_req_rdy = 1'b1;

  always_ff @(posedge clk) begin
    if (wr_req_val) begin
      for (int i = 0; i < mask_w_p; i++) begin
        if (wr_req_mask[i]) mem[wr_req_addr][i*BYTE_W +: BYTE_W] <= wr_req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Stage p0 -> p1: write capture shared by every channel's bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcap_vld_p1  <= 1'b0;
      wcap_addr_p1 <= '0;
      wcap_data_p1 <= '0;
      wcap_mask_p1 <= '0;
    end else begin
      wcap_vld_p1  <= wr_req_val;
      wcap_addr_p1 <= wr_req_addr;
      wcap_data_p1 <= wr_req_data;
      wcap_mask_p1 <= wr_req_mask;
    end
  end

  for (genvar k = 0; k < num_rd_ports_p; k++) begin : g_chan
    logic                issue_en;
    logic [addr_w_p-1:0] issue_addr;
    logic [width_p-1:0]  raw_p1;

    // Stage p0 -> p1: array read, old data on a same-address write.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) raw_p1 <= '0;
      else if (issue_en) raw_p1 <= mem[issue_addr];
    end

    ram_rd_chan_ctrl #(
      .width_p  (width_p),
      .addr_w_p (addr_w_p),
      .mask_w_p (mask_w_p)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .req_val    (rd_req_val[k]),
      .req_addr   (rd_req_addr[k*addr_w_p +: addr_w_p]),
      .req_rdy    (rd_req_rdy[k]),
      .resp_val   (rd_resp_val[k]),
      .resp_data  (rd_resp_data[k*width_p +: width_p]),
      .resp_rdy   (rd_resp_rdy[k]),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .raw_data   (raw_p1),
      .wcap_val   (wcap_vld_p1),
      .wcap_addr  (wcap_addr_p1),
      .wcap_data  (wcap_data_p1),
      .wcap_mask  (wcap_mask_p1)
    );

`ifndef SYNTHESIS
    a_rd_addr_range: assert property (@(posedge clk) disable iff (rst)
      issue_en |-> ({1'b0, issue_addr} < (addr_w_p+1)'(els_p)));
`endif
  end

`ifndef SYNTHESIS
  a_wr_addr_range: assert property (@(posedge clk) disable iff (rst)
    wr_req_val |-> ({1'b0, wr_req_addr} < (addr_w_p+1)'(els_p)));
`endif

endmodule

// File: tb/tb_ram_1wnr_sync_backpressure.sv
// Bench: directed vector table, reset corner cases, then randomized traffic against a memory model.
module tb_ram_1wnr_sync_backpressure;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_req_val;
  logic [7:0]   wr_req_addr;
  logic [63:0]  wr_req_data;
  logic [7:0]   wr_req_mask;
  logic         wr_req_rdy;
  logic [1:0]   rd_req_val;
  logic [15:0]  rd_req_addr;
  logic [1:0]   rd_req_rdy;
  logic [1:0]   rd_resp_val;
  logic [127:0] rd_resp_data;
  logic [1:0]   rd_resp_rdy;

  int checks   = 0;
  int failures = 0;

  logic [63:0] mdl [256];
  logic        pend  [2];
  logic [7:0]  paddr [2];

  typedef struct {
    logic        wv;
    logic [7:0]  wa;
    logic [63:0] wd;
    logic [7:0]  wm;
    logic [1:0]  rv;
    logic [7:0]  ra0;
    logic [7:0]  ra1;
    logic [1:0]  rr;
    logic [1:0]  ev;
    logic [1:0]  er;
    logic [63:0] ed0;
    logic [63:0] ed1;
  } vec_t;

  vec_t tbl [14];

  ram_1wnr_sync_backpressure dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req_val   (wr_req_val),
    .wr_req_addr  (wr_req_addr),
    .wr_req_data  (wr_req_data),
    .wr_req_mask  (wr_req_mask),
    .wr_req_rdy   (wr_req_rdy),
    .rd_req_val   (rd_req_val),
    .rd_req_addr  (rd_req_addr),
    .rd_req_rdy   (rd_req_rdy),
    .rd_resp_val  (rd_resp_val),
    .rd_resp_data (rd_resp_data),
    .rd_resp_rdy  (rd_resp_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory and outstanding-request bookkeeping for the edge about to happen.
  task automatic model_commit();
    logic rdy;
    if (wr_req_val) begin
      for (int b = 0; b < 8; b++)
        if (wr_req_mask[b]) mdl[wr_req_addr][b*8 +: 8] = wr_req_data[b*8 +: 8];
    end
    for (int k = 0; k < 2; k++) begin
      rdy = !pend[k] || rd_resp_rdy[k];
      if (pend[k] && rd_resp_rdy[k]) pend[k] = 1'b0;
      if (rd_req_val[k] && rdy) begin
        pend[k]  = 1'b1;
        paddr[k] = rd_req_addr[k*8 +: 8];
      end
    end
  endtask

  task automatic step();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_req_val  = 1'b0;
    wr_req_addr = '0;
    wr_req_data = '0;
    wr_req_mask = '0;
    rd_req_val  = '0;
    rd_req_addr = '0;
    rd_resp_rdy = 2'b11;
  endtask

  task automatic apply(input vec_t v);
    wr_req_val  = v.wv;
    wr_req_addr = v.wa;
    wr_req_data = v.wd;
    wr_req_mask = v.wm;
    rd_req_val  = v.rv;
    rd_req_addr = {v.ra1, v.ra0};
    rd_resp_rdy = v.rr;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'd5, 64'h1122334455667788, 8'hFF, 2'b00, 8'd0, 8'd0,  2'b11, 2'b00, 2'b11, 64'd0, 64'd0};
    tbl[1]  = '{1'b0, 8'd0, 64'd0, 8'h00, 2'b01, 8'd5, 8'd0,                 2'b11, 2'b00, 2'b11, 64'd0, 64'd0};
    tbl[2]  = '{1'b0, 8'd0, 64'd0, 8'h00, 2'b00, 8'd0, 8'd0,                 2'b11, 2'b01, 2'b11, 64'h1122334455667788, 64'd0};
    tbl[3]  = '{1'b1, 8'd7, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 2'b10, 8'd0, 8'd7,  2'b11, 2'b00, 2'b11, 64'd0, 64'd0};
    tbl[4]  = '{1'b0, 8'd0, 64'd0, 8'h00, 2'b00, 8'd0, 8'd0,                 2'b11, 2'b10, 2'b11, 64'd0, 64'h00000000FFFFFFFF};
    tbl[5]  = '{1'b0, 8'd0, 64'd0, 8'h00, 2'b11, 8'd3, 8'd20,                2'b11, 2'b00, 2'b11, 64'd0, 64'd0};
    tbl[6]  = '{1'b0, 8'd0, 64'd0, 8'h00, 2'b10, 8'd0, 8'd21,                2'b10, 2'b11, 2'b10, 64'hA, 64'h114};
    tbl[7]  = '{1'b1, 8'd3, 64'hB, 8'hFF, 2'b10, 8'd0, 8'd22,                2'b10, 2'b11, 2'b10, 64'hA, 64'h115};
    tbl[8]  = '{1'b0, 8'd0, 64'd0, 8'h00, 2'b10, 8'd0, 8'd23,                2'b10, 2'b11, 2'b10, 64'hB, 64'h116};
    tbl[9]  = '{1'b0, 8'd0, 64'd0, 8'h00, 2'b10, 8'd0, 8'd24,                2'b11, 2'b11, 2'b11, 64'hB, 64'h117};
    tbl[10] = '{1'b0, 8'd0, 64'd0, 8'h00, 2'b00, 8'd0, 8'd0,                 2'b11, 2'b10, 2'b11, 64'd0, 64'h118};
    tbl[11] = '{1'b1, 8'd9, 64'hEE11223344556677, 8'h80, 2'b11, 8'd9, 8'd9,  2'b11, 2'b00, 2'b11, 64'd0, 64'd0};
    tbl[12] = '{1'b0, 8'd0, 64'd0, 8'h00, 2'b00, 8'd0, 8'd0,                 2'b11, 2'b11, 2'b11, 64'hEE02030405060708, 64'hEE02030405060708};
    tbl[13] = '{1'b0, 8'd0, 64'd0, 8'h00, 2'b00, 8'd0, 8'd0,                 2'b11, 2'b00, 2'b11, 64'd0, 64'd0};

    pend[0] = 1'b0; pend[1] = 1'b0;
    paddr[0] = '0;  paddr[1] = '0;
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_resp_val", 64'(rd_resp_val), 64'(2'b00));
    chk("rst_req_rdy", 64'(rd_req_rdy), 64'(2'b11));
    chk("rst_wr_rdy", 64'(wr_req_rdy), 64'(1'b1));
    chk("rst_data0", rd_resp_data[63:0], 64'd0);
    chk("rst_data1", rd_resp_data[127:64], 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("post_rst_idle", 64'(rd_resp_val), 64'(2'b00));
      step();
    end

    // Preload every word so the array is fully defined.
    for (int a = 0; a < 256; a++) begin
      wr_req_val  = 1'b1;
      wr_req_addr = 8'(a);
      wr_req_mask = 8'hFF;
      if (a == 3)                 wr_req_data = 64'hA;
      else if (a == 9)            wr_req_data = 64'h0102030405060708;
      else if (a >= 20 && a < 26) wr_req_data = 64'h100 + 64'(a);
      else                        wr_req_data = 64'd0;
      step();
    end
    idle();
    step();

    for (int r = 0; r < 14; r++) begin
      apply(tbl[r]);
      #1;
      chk($sformatf("vec%0d_val", r), 64'(rd_resp_val), 64'(tbl[r].ev));
      chk($sformatf("vec%0d_rdy", r), 64'(rd_req_rdy), 64'(tbl[r].er));
      if (tbl[r].ev[0]) chk($sformatf("vec%0d_d0", r), rd_resp_data[63:0], tbl[r].ed0);
      if (tbl[r].ev[1]) chk($sformatf("vec%0d_d1", r), rd_resp_data[127:64], tbl[r].ed1);
      step();
    end
    idle();

    // Reset while ch0 holds a stalled response.
    rd_req_val  = 2'b01;
    rd_req_addr = {8'd0, 8'd5};
    rd_resp_rdy = 2'b10;
    step();
    rd_req_val = 2'b00;
    #1;
    chk("stall_val", 64'(rd_resp_val), 64'(2'b01));
    chk("stall_data", rd_resp_data[63:0], 64'h1122334455667788);
    step();
    chk("stall_hold", 64'(rd_resp_val), 64'(2'b01));
    chk("stall_rdy", 64'(rd_req_rdy), 64'(2'b10));
    rst = 1'b1;
    #1;
    chk("async_rst_val", 64'(rd_resp_val), 64'(2'b00));
    chk("async_rst_rdy", 64'(rd_req_rdy), 64'(2'b11));
    chk("async_rst_data", rd_resp_data[63:0], 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("after_rst_no_resp", 64'(rd_resp_val), 64'(2'b00));
      step();
    end
    rd_req_val  = 2'b01;
    rd_req_addr = {8'd0, 8'd5};
    rd_resp_rdy = 2'b11;
    step();
    rd_req_val = 2'b00;
    #1;
    chk("new_req_val", 64'(rd_resp_val), 64'(2'b01));
    chk("new_req_data", rd_resp_data[63:0], 64'h1122334455667788);
    step();
    idle();
    step();

    // Randomized traffic on a small address window to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      wr_req_val  = 1'($urandom_range(0, 1));
      wr_req_addr = 8'($urandom_range(0, 15));
      wr_req_data = {$urandom, $urandom};
      wr_req_mask = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      rd_req_val  = 2'($urandom);
      rd_req_addr = {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))};
      rd_resp_rdy = {1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6)};
      #1;
      chk("rnd_wr_rdy", 64'(wr_req_rdy), 64'(1'b1));
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rnd_c%0d_val%0d", c, k), 64'(rd_resp_val[k]), 64'(pend[k]));
        chk($sformatf("rnd_c%0d_rdy%0d", c, k), 64'(rd_req_rdy[k]), 64'(!pend[k] || rd_resp_rdy[k]));
        if (pend[k]) chk($sformatf("rnd_c%0d_data%0d", c, k), rd_resp_data[k*64 +: 64], mdl[paddr[k]]);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
